keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan_if.sv | 15 +
 rtl/keypad_scan.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
// Keypad-facing signal bundle of keypad_scan: row drive, column sense and the
// decoded key outputs.
interface keypad_scan_if;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [15:0] onehot;
   logic        key_valid;
   logic        key_down;

   // Handshake: key_valid is a one-cycle strobe with no ready/back-pressure;
   // the consumer takes onehot in the cycle key_valid is high (onehot also
   // stays held afterwards until the next accepted press).
   modport master (input col, output row, onehot, key_valid, key_down);
   modport slave  (output col, input row, onehot, key_valid, key_down);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks the rows, assembles a 16-bit frame per full
// scan and debounces single-key presses/releases over whole frames.
module keypad_scan #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic          clk,
   input  logic          rst,
   keypad_scan_if.master kp,
   output logic [1:0]    state_o
);

   localparam int            CW         = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
   localparam logic [3:0]    DF         = 4'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESS_CHK = 2'd1,
      ST_HELD      = 2'd2,
      ST_REL_CHK   = 2'd3
   } state_e;

   logic [3:0]    col_meta_q;
   logic [3:0]    col_sync_q;
   logic [CW-1:0] dwell_q;
   logic [1:0]    row_idx_q;
   logic [1:0]    row_idx_d;
   logic [3:0]    row_q;
   logic [15:0]   frame_q;
   logic [15:0]   frame_d;

   state_e        state_q;
   logic [3:0]    cnt_q;
   logic [15:0]   cand_q;
   logic [15:0]   onehot_q;
   logic          key_valid_q;
   logic          key_down_q;

   logic          last_dwell;
   logic          frame_done;
   logic          frame_none;
   logic          frame_single;
   logic [3:0]    press_cnt_d;
   logic [3:0]    rel_cnt_d;

   // frame_d already contains the current row's sample, so on the last dwell
   // cycle of row 3 it is the complete frame and can be classified at once.
   always_comb begin
      last_dwell   = (dwell_q == DWELL_LAST);
      frame_done   = last_dwell && (row_idx_q == 2'd3);
      row_idx_d    = row_idx_q + 2'd1;
      frame_d      = frame_q;
      frame_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
      frame_none   = (frame_d == 16'h0000);
      frame_single = !frame_none && ((frame_d & (frame_d - 16'd1)) == 16'h0000);
      press_cnt_d  = ((state_q == ST_PRESS_CHK) && (frame_d == cand_q)) ? cnt_q + 4'd1 : 4'd1;
      rel_cnt_d    = (state_q == ST_REL_CHK) ? cnt_q + 4'd1 : 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_meta_q <= 4'hF;
         col_sync_q <= 4'hF;
         dwell_q    <= '0;
         row_idx_q  <= 2'd0;
         row_q      <= 4'b1110;
         frame_q    <= 16'h0000;
      end else begin
         col_meta_q <= kp.col;
         col_sync_q <= col_meta_q;
         if (last_dwell) begin
            dwell_q   <= '0;
            row_idx_q <= row_idx_d;
            row_q     <= ~(4'b0001 << row_idx_d);
            frame_q   <= frame_d;
         end else begin
            dwell_q <= dwell_q + CW'(1);
         end
      end
   end

   // Debounce: counts are stored only while below DF; reaching DF changes state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         cand_q      <= 16'h0000;
         onehot_q    <= 16'h0000;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         if (frame_done) begin
            unique case (state_q)
               ST_IDLE, ST_PRESS_CHK: begin
                  if (frame_single) begin
                     cand_q <= frame_d;
                     if (press_cnt_d == DF) begin
                        state_q     <= ST_HELD;
                        cnt_q       <= 4'd0;
                        onehot_q    <= frame_d;
                        key_valid_q <= 1'b1;
                        key_down_q  <= 1'b1;
                     end else begin
                        state_q <= ST_PRESS_CHK;
                        cnt_q   <= press_cnt_d;
                     end
                  end else begin
                     state_q <= ST_IDLE;
                     cnt_q   <= 4'd0;
                  end
               end
               ST_HELD, ST_REL_CHK: begin
                  if (frame_none) begin
                     if (rel_cnt_d == DF) begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= 4'd0;
                        key_down_q <= 1'b0;
                     end else begin
                        state_q <= ST_REL_CHK;
                        cnt_q   <= rel_cnt_d;
                     end
                  end else begin
                     state_q <= ST_HELD;
                     cnt_q   <= 4'd0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= 4'd0;
               end
            endcase
         end
      end
   end

   assign kp.row       = row_q;
   assign kp.onehot    = onehot_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_down  = key_down_q;
   assign state_o      = state_q;

endmodule
